pc_unit: RTL

Fetch-stage program-counter unit for the five-stage MIPS pipeline. It owns the architectural fetch PC register and computes the next PC from the decode-stage control: sequential, branch, jump or register jump. Beyond plain next-PC selection it handles pipeline stalls, latches a redirect that resolves during a stall, and supports exception entry and `eret` return. It sits between the hazard unit and decode stage on the input side and the instruction memory on the output side.

---
 rtl/pc_unit_pkg.sv | 19 +
 rtl/pc_unit_npc_target.sv | 48 ++++
 rtl/pc_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the fetch PC unit: next-PC mode encodings,
// default reset / exception addresses and the fetch state type.
package pc_unit_pkg;

    localparam logic [2:0] NPC_ADD4 = 3'd0;
    localparam logic [2:0] NPC_BRCH = 3'd1;
    localparam logic [2:0] NPC_J    = 3'd2;
    localparam logic [2:0] NPC_JR   = 3'd3;
    localparam logic [2:0] NPC_RST  = 3'd4;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_DEFAULT   = 32'h0000_4180;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_unit_npc_target.sv
// Combinational next-PC target calculator for branch, j, jr and rst modes.
// taken is high for every mode that leaves the sequential path.
module npc_target
    import pc_unit_pkg::*;
#(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(PC_RESET_DEFAULT)
) (
    input  logic [2:0]       npc_mod,
    input  logic [WIDTH-1:0] D_pc,
    input  logic [25:0]      imm26,
    input  logic [WIDTH-1:0] reg32,
    output logic [WIDTH-1:0] target,
    output logic             taken
);

    logic [WIDTH-1:0] brchOffset;

    assign brchOffset = {{(WIDTH-18){imm26[15]}}, imm26[15:0], 2'b00};

    always_comb begin
        target = '0;
        taken  = 1'b0;
        case (npc_mod)
            NPC_BRCH: begin
                target = D_pc + WIDTH'(4) + brchOffset;
                taken  = 1'b1;
            end
            NPC_J: begin
                target = {D_pc[WIDTH-1:28], imm26, 2'b00};
                taken  = 1'b1;
            end
            NPC_JR: begin
                target = reg32;
                taken  = 1'b1;
            end
            NPC_RST: begin
                target = RESET_PC;
                taken  = 1'b1;
            end
            default: begin
                target = '0;
                taken  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC register with stall-tolerant redirect latching and exception/eret entry.
// Optional misaligned jr/eret target trapping is enabled by defining PC_ALIGN_CHECK_EN.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(PC_RESET_DEFAULT),
    parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(PC_EXC_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [2:0]       npc_mod,
    input  logic [WIDTH-1:0] D_pc,
    input  logic [25:0]      imm26,
    input  logic [WIDTH-1:0] reg32,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc_in,
    output logic [WIDTH-1:0] F_pc,
    output logic             redirect,
    output logic             pend_valid,
    output logic             adel
);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic             pend_adel_q, pend_adel_d;
    logic             redirect_q, redirect_d;
    logic             adel_q, adel_d;

    logic [WIDTH-1:0] target;
    logic             taken;
    logic             tgtBad;
    logic             eretBad;
    logic [WIDTH-1:0] tgtSafe;

    npc_target #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_npc_target (
        .npc_mod (npc_mod),
        .D_pc    (D_pc),
        .imm26   (imm26),
        .reg32   (reg32),
        .target  (target),
        .taken   (taken)
    );

`ifdef PC_ALIGN_CHECK_EN
    assign tgtBad  = (npc_mod == NPC_JR) && (target[1:0] != 2'b00);
    assign eretBad = (epc_in[1:0] != 2'b00);
`else
    assign tgtBad  = 1'b0;
    assign eretBad = 1'b0;
`endif

    // A misaligned target is swapped for the handler vector at capture time.
    assign tgtSafe = tgtBad ? EXC_VEC : target;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        pend_adel_d = pend_adel_q;
        redirect_d  = 1'b0;
        adel_d      = 1'b0;
        if (exc_req) begin
            pc_d        = EXC_VEC;
            pend_pc_d   = '0;
            pend_adel_d = 1'b0;
            state_d     = ST_RUN;
            redirect_d  = 1'b1;
        end else if (eret) begin
            pc_d        = eretBad ? EXC_VEC : epc_in;
            adel_d      = eretBad;
            pend_pc_d   = '0;
            pend_adel_d = 1'b0;
            state_d     = ST_RUN;
            redirect_d  = 1'b1;
        end else if (state_q == ST_PEND) begin
            if (!stall) begin
                pc_d        = pend_pc_q;
                adel_d      = pend_adel_q;
                pend_adel_d = 1'b0;
                state_d     = ST_RUN;
                redirect_d  = 1'b1;
            end
        end else if (taken) begin
            if (stall) begin
                pend_pc_d   = tgtSafe;
                pend_adel_d = tgtBad;
                state_d     = ST_PEND;
            end else begin
                pc_d       = tgtSafe;
                adel_d     = tgtBad;
                redirect_d = 1'b1;
            end
        end else if (!stall) begin
            pc_d = pc_q + WIDTH'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            pend_pc_q   <= '0;
            pend_adel_q <= 1'b0;
            redirect_q  <= 1'b0;
            adel_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            pend_adel_q <= pend_adel_d;
            redirect_q  <= redirect_d;
            adel_q      <= adel_d;
        end
    end

    assign F_pc       = pc_q;
    assign redirect   = redirect_q;
    assign pend_valid = (state_q == ST_PEND);
    assign adel       = adel_q;

endmodule
